// File: rtl/vga_if.sv
// VGA timing bundle: pixel/line counters plus sync and blank, shared by the
// timing source and every renderer that consumes it.
interface vga_if #(
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10
);
    logic [HCOUNT_WIDTH-1:0] hcount;
    logic [VCOUNT_WIDTH-1:0] vcount;
    logic                    hsync;
    logic                    vsync;
    logic                    blank;

    modport src (output hcount, vcount, hsync, vsync, blank);
    modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source (640x480@60 by default). Counters advance on a
// pixel-enable strobe in the system clock domain; sync/blank are decoded
// from the next counter state and registered alongside the counters so all
// outputs change together with zero skew.
module vga_timing_gen #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic SYNC_ACTIVE  = 1'b0,
    parameter int   HCOUNT_WIDTH = 10,
    parameter int   VCOUNT_WIDTH = 10
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pix_en_in,
    vga_if.src   vga_out,
    output logic line_start_out,
    output logic frame_start_out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL - 1 >= (1 << HCOUNT_WIDTH)) begin : g_h_width_chk
            $error("vga_timing_gen: H_TOTAL-1 does not fit in HCOUNT_WIDTH");
        end
        if (V_TOTAL - 1 >= (1 << VCOUNT_WIDTH)) begin : g_v_width_chk
            $error("vga_timing_gen: V_TOTAL-1 does not fit in VCOUNT_WIDTH");
        end
    endgenerate

    localparam logic [HCOUNT_WIDTH-1:0] H_LAST     = HCOUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [VCOUNT_WIDTH-1:0] V_LAST     = VCOUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [HCOUNT_WIDTH-1:0] H_BLANK_AT = HCOUNT_WIDTH'(H_ACTIVE);
    localparam logic [VCOUNT_WIDTH-1:0] V_BLANK_AT = VCOUNT_WIDTH'(V_ACTIVE);
    localparam logic [HCOUNT_WIDTH-1:0] HS_START   = HCOUNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [HCOUNT_WIDTH-1:0] HS_END     = HCOUNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCOUNT_WIDTH-1:0] VS_START   = VCOUNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [VCOUNT_WIDTH-1:0] VS_END     = VCOUNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCOUNT_WIDTH-1:0] h_q, h_next;
    logic [VCOUNT_WIDTH-1:0] v_q, v_next;
    logic                    h_wrap, v_wrap;
    logic                    hsync_q, vsync_q, blank_q;
    logic                    hsync_next, vsync_next, blank_next;

    // Next raster position; vcount only moves on the edge where hcount wraps.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_next = h_wrap ? '0 : h_q + 1'b1;
        v_next = v_q;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_q + 1'b1;
        end
    end

    // Decode sync/blank from the position that will be presented next, so the
    // registered decode lines up with the registered counters.
    always_comb begin
        blank_next = (h_next >= H_BLANK_AT) || (v_next >= V_BLANK_AT);
        hsync_next = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Counter/decode registers plus strobes; strobes self-clear on the next clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            h_q             <= '0;
            v_q             <= '0;
            blank_q         <= 1'b0;
            hsync_q         <= ~SYNC_ACTIVE;
            vsync_q         <= ~SYNC_ACTIVE;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            line_start_out  <= pix_en_in && h_wrap;
            frame_start_out <= pix_en_in && h_wrap && v_wrap;
            if (pix_en_in) begin
                h_q     <= h_next;
                v_q     <= v_next;
                blank_q <= blank_next;
                hsync_q <= hsync_next;
                vsync_q <= vsync_next;
            end
        end
    end

    assign vga_out.hcount = h_q;
    assign vga_out.vcount = v_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.blank  = blank_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A uses the real 640x480 timing for
// line-level checks; instance B uses a 16x12 raster (active 8x6, hsync at
// h=10..12, vsync at v=8..9) so full frames fit in a short run.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    logic pe_a, pe_b;
    logic ls_a, fs_a, ls_b, fs_b;
    int   total = 0;
    int   bad   = 0;

    vga_if #(.HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10)) va ();
    vga_if #(.HCOUNT_WIDTH(4),  .VCOUNT_WIDTH(4))  vb ();

    always #5 clk = ~clk;

    vga_timing_gen #(.HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10)) u_a (
        .clk_in(clk), .rst_in(rst), .pix_en_in(pe_a), .vga_out(va),
        .line_start_out(ls_a), .frame_start_out(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HCOUNT_WIDTH(4), .VCOUNT_WIDTH(4)
    ) u_b (
        .clk_in(clk), .rst_in(rst), .pix_en_in(pe_b), .vga_out(vb),
        .line_start_out(ls_b), .frame_start_out(fs_b)
    );

    task automatic test_reset;
        rst = 1'b1; pe_a = 1'b0; pe_b = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (va.hcount !== 10'd0) begin bad++; $display("FAIL rst_a_h got %0d want 0", va.hcount); end
        total++; if (va.vcount !== 10'd0) begin bad++; $display("FAIL rst_a_v got %0d want 0", va.vcount); end
        total++; if (va.blank !== 1'b0) begin bad++; $display("FAIL rst_a_blank got %b want 0", va.blank); end
        total++; if (va.hsync !== 1'b1) begin bad++; $display("FAIL rst_a_hsync got %b want 1", va.hsync); end
        total++; if (va.vsync !== 1'b1) begin bad++; $display("FAIL rst_a_vsync got %b want 1", va.vsync); end
        total++; if ({ls_a, fs_a} !== 2'b00) begin bad++; $display("FAIL rst_a_strobes got %b want 00", {ls_a, fs_a}); end
        total++; if ({vb.hcount, vb.vcount} !== 8'h00) begin bad++; $display("FAIL rst_b_hv got %h want 00", {vb.hcount, vb.vcount}); end
        total++; if ({vb.blank, vb.hsync, vb.vsync, ls_b, fs_b} !== 5'b01100) begin bad++; $display("FAIL rst_b_ctl got %b want 01100", {vb.blank, vb.hsync, vb.vsync, ls_b, fs_b}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({va.hcount, ls_a, fs_a} !== 12'd0) begin bad++; $display("FAIL rst_hold_a got h=%0d ls=%b fs=%b want 0 0 0", va.hcount, ls_a, fs_a); end
    endtask

    task automatic test_line0;
        int h, v, hs_low, blank_hi, ls_cnt, fs_cnt;
        logic exp_b, exp_hs;
        hs_low = 0; blank_hi = 0; ls_cnt = 0; fs_cnt = 0;
        pe_a = 1'b1;
        for (int k = 1; k <= 1600; k++) begin
            @(negedge clk);
            h = k % 800; v = k / 800;
            exp_b  = (h >= 640);
            exp_hs = !(h >= 656 && h < 752);
            total++; if (va.hcount !== 10'(h) || va.vcount !== 10'(v)) begin bad++; $display("FAIL line_hv got (%0d,%0d) want (%0d,%0d)", va.hcount, va.vcount, h, v); end
            total++; if (va.blank !== exp_b) begin bad++; $display("FAIL line_blank h=%0d got %b want %b", h, va.blank, exp_b); end
            total++; if (va.hsync !== exp_hs) begin bad++; $display("FAIL line_hsync h=%0d got %b want %b", h, va.hsync, exp_hs); end
            total++; if (ls_a !== (h == 0)) begin bad++; $display("FAIL line_ls h=%0d got %b want %b", h, ls_a, (h == 0)); end
            total++; if (va.vsync !== 1'b1) begin bad++; $display("FAIL line_vsync v=%0d got %b want 1", v, va.vsync); end
            if (va.hsync === 1'b0) hs_low++;
            if (va.blank === 1'b1) blank_hi++;
            if (ls_a === 1'b1) ls_cnt++;
            if (fs_a === 1'b1) fs_cnt++;
        end
        total++; if (hs_low !== 192) begin bad++; $display("FAIL line_hs_low_count got %0d want 192", hs_low); end
        total++; if (blank_hi !== 320) begin bad++; $display("FAIL line_blank_count got %0d want 320", blank_hi); end
        total++; if (ls_cnt !== 2) begin bad++; $display("FAIL line_ls_count got %0d want 2", ls_cnt); end
        total++; if (fs_cnt !== 0) begin bad++; $display("FAIL line_fs_count got %0d want 0", fs_cnt); end
        pe_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (va.hcount !== 10'd0 || va.vcount !== 10'd2 || ls_a !== 1'b0) begin bad++; $display("FAIL hold_a got (%0d,%0d) ls=%b want (0,2) ls=0", va.hcount, va.vcount, ls_a); end
        end
    endtask

    task automatic test_frame;
        int h, v, ls_cnt, fs_cnt, unblank, vs_low;
        ls_cnt = 0; fs_cnt = 0; unblank = 0; vs_low = 0;
        pe_b = 1'b1;
        for (int k = 1; k <= 192; k++) begin
            @(negedge clk);
            h = k % 16; v = (k / 16) % 12;
            total++; if (vb.hcount !== 4'(h) || vb.vcount !== 4'(v)) begin bad++; $display("FAIL frame_hv got (%0d,%0d) want (%0d,%0d)", vb.hcount, vb.vcount, h, v); end
            total++; if (vb.blank !== ((h >= 8) || (v >= 6))) begin bad++; $display("FAIL frame_blank (%0d,%0d) got %b", h, v, vb.blank); end
            total++; if (vb.hsync !== !(h >= 10 && h < 13)) begin bad++; $display("FAIL frame_hsync h=%0d got %b", h, vb.hsync); end
            total++; if (vb.vsync !== !(v >= 8 && v < 10)) begin bad++; $display("FAIL frame_vsync v=%0d got %b", v, vb.vsync); end
            total++; if (ls_b !== (h == 0) || fs_b !== (k == 192)) begin bad++; $display("FAIL frame_strobes k=%0d got ls=%b fs=%b", k, ls_b, fs_b); end
            if (ls_b === 1'b1) ls_cnt++;
            if (fs_b === 1'b1) fs_cnt++;
            if (vb.blank === 1'b0) unblank++;
            if (vb.vsync === 1'b0) vs_low++;
        end
        total++; if (ls_cnt !== 12) begin bad++; $display("FAIL frame_ls_count got %0d want 12", ls_cnt); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL frame_fs_count got %0d want 1", fs_cnt); end
        total++; if (unblank !== 48) begin bad++; $display("FAIL frame_unblank got %0d want 48", unblank); end
        total++; if (vs_low !== 32) begin bad++; $display("FAIL frame_vs_low got %0d want 32", vs_low); end
    endtask

    task automatic test_pix_en_random;
        int mh, mv, en_cnt, fs_cnt, cyc;
        logic en, exp_ls, exp_fs;
        logic [3:0] pat;
        pat = 4'b1001;
        mh = 0; mv = 0; en_cnt = 0; fs_cnt = 0; cyc = 0;
        while (en_cnt < 192 && cyc < 3000) begin
            en = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
            pe_b = en;
            exp_ls = 1'b0; exp_fs = 1'b0;
            if (en) begin
                en_cnt++;
                mh = mh + 1;
                if (mh == 16) begin
                    mh = 0; exp_ls = 1'b1;
                    mv = mv + 1;
                    if (mv == 12) begin mv = 0; exp_fs = 1'b1; end
                end
            end
            @(negedge clk);
            cyc++;
            total++; if (vb.hcount !== 4'(mh) || vb.vcount !== 4'(mv)) begin bad++; $display("FAIL rand_hv cyc=%0d got (%0d,%0d) want (%0d,%0d)", cyc, vb.hcount, vb.vcount, mh, mv); end
            total++; if (ls_b !== exp_ls || fs_b !== exp_fs) begin bad++; $display("FAIL rand_strobes cyc=%0d got ls=%b fs=%b want %b %b", cyc, ls_b, fs_b, exp_ls, exp_fs); end
            total++; if (vb.blank !== ((mh >= 8) || (mv >= 6))) begin bad++; $display("FAIL rand_blank (%0d,%0d) got %b", mh, mv, vb.blank); end
            if (fs_b === 1'b1) fs_cnt++;
        end
        total++; if (en_cnt !== 192) begin bad++; $display("FAIL rand_budget got %0d enabled edges want 192", en_cnt); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL rand_fs_count got %0d want 1", fs_cnt); end
        pe_b = 1'b0;
    endtask

    task automatic test_wrap;
        pe_b = 1'b1;
        repeat (191) @(negedge clk);
        total++; if (vb.hcount !== 4'd15 || vb.vcount !== 4'd11) begin bad++; $display("FAIL wrap_pre got (%0d,%0d) want (15,11)", vb.hcount, vb.vcount); end
        total++; if ({vb.blank, vb.hsync, vb.vsync, ls_b, fs_b} !== 5'b11100) begin bad++; $display("FAIL wrap_pre_ctl got %b want 11100", {vb.blank, vb.hsync, vb.vsync, ls_b, fs_b}); end
        @(negedge clk);
        total++; if (vb.hcount !== 4'd0 || vb.vcount !== 4'd0) begin bad++; $display("FAIL wrap_hv got (%0d,%0d) want (0,0)", vb.hcount, vb.vcount); end
        total++; if ({vb.blank, vb.vsync, ls_b, fs_b} !== 4'b0111) begin bad++; $display("FAIL wrap_ctl got %b want 0111", {vb.blank, vb.vsync, ls_b, fs_b}); end
        pe_b = 1'b0;
        @(negedge clk);
        total++; if ({ls_b, fs_b} !== 2'b00 || vb.hcount !== 4'd0) begin bad++; $display("FAIL wrap_clear got ls=%b fs=%b h=%0d want 0 0 0", ls_b, fs_b, vb.hcount); end
    endtask

    task automatic test_async_reset;
        pe_a = 1'b1; pe_b = 1'b1;
        repeat (700) @(negedge clk);
        total++; if (va.hcount !== 10'd700 || va.vcount !== 10'd2) begin bad++; $display("FAIL ares_pre got (%0d,%0d) want (700,2)", va.hcount, va.vcount); end
        total++; if (va.hsync !== 1'b0 || va.blank !== 1'b1) begin bad++; $display("FAIL ares_pre_ctl got hs=%b bl=%b want 0 1", va.hsync, va.blank); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (va.hcount !== 10'd0 || va.vcount !== 10'd0) begin bad++; $display("FAIL ares_a_hv got (%0d,%0d) want (0,0)", va.hcount, va.vcount); end
        total++; if ({va.blank, va.hsync, va.vsync, ls_a, fs_a} !== 5'b01100) begin bad++; $display("FAIL ares_a_ctl got %b want 01100", {va.blank, va.hsync, va.vsync, ls_a, fs_a}); end
        total++; if ({vb.hcount, vb.vcount} !== 8'h00) begin bad++; $display("FAIL ares_b_hv got %h want 00", {vb.hcount, vb.vcount}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (va.hcount !== 10'd1 || va.vcount !== 10'd0 || {ls_a, fs_a} !== 2'b00) begin bad++; $display("FAIL ares_restart got (%0d,%0d) ls=%b fs=%b want (1,0) 0 0", va.hcount, va.vcount, ls_a, fs_a); end
        total++; if (vb.hcount !== 4'd1 || {ls_b, fs_b} !== 2'b00) begin bad++; $display("FAIL ares_restart_b got h=%0d ls=%b fs=%b want 1 0 0", vb.hcount, ls_b, fs_b); end
        pe_a = 1'b0; pe_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pe_a = 1'b0; pe_b = 1'b0;
        test_reset();
        test_line0();
        test_frame();
        test_pix_en_random();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
